mcu_spi_slave: RTL

//   SPI slave (mode 0, MSB first) between the board MCU and the system control block.

---
 rtl/mcu_spi_slave_if.sv | 26 ++
 rtl/mcu_spi_slave.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mcu_spi_slave_if.sv
// Bus between the MCU SPI pins, the control block and mcu_spi_slave.
//   spi_io_ss/clk/din : MCU pins into the slave (asynchronous)
//   spi_io_dout       : MISO back to the MCU
//   data_in/_strobe/_start : received byte stream to the control block
//   data_out          : reply byte from the control block
// slave modport is the SPI slave; master modport is the MCU + control block side.
interface mcu_spi_slave_if;
  logic       spi_io_ss;
  logic       spi_io_clk;
  logic       spi_io_din;
  logic       spi_io_dout;
  logic [7:0] data_in;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_out;

  modport slave (
    input  spi_io_ss, spi_io_clk, spi_io_din, data_out,
    output spi_io_dout, data_in, data_in_strobe, data_in_start
  );

  modport master (
    output spi_io_ss, spi_io_clk, spi_io_din, data_out,
    input  spi_io_dout, data_in, data_in_strobe, data_in_start
  );
endinterface

// File: rtl/mcu_spi_slave.sv
// SPI slave, mode 0, MSB first, oversampled in the clk domain.
//   clk      : system clock
//   reset_n  : synchronous reset, active low
//   bus      : mcu_spi_slave_if.slave (SPI pins, received byte stream, reply byte)
// Received bytes come out on data_in with a one-clk data_in_strobe; data_in_start
// marks the first byte of a chip-select frame. The reply register tx_sr is loaded
// from data_out at frame start and two clocks after each strobe, so the reply to
// byte N is shifted out on MISO during byte N+1.
module mcu_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset_n,
  mcu_spi_slave_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, din_sync;
  logic                   ss_h, sck_h;
  // Marks when the history flop holds a real pin sample rather than its reset
  // value; blocks a false ss fall when ss is already low at reset release.
  logic [SYNC_STAGES:0]   fill;

  logic       ss_s, sck_s, din_s;
  logic       ss_fall, sck_rise, sck_fall;
  logic       start_xfer, abort;

  logic [7:0] rx_sr, tx_sr;
  logic [2:0] bit_cnt;
  logic       first;
  logic       byte_done;   // 8th bit captured, strobe goes out next clk
  logic       reload_pend; // strobe seen last clk, control block reply valid now

  assign ss_s  = ss_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign din_s = din_sync[SYNC_STAGES-1];

  assign ss_fall  = fill[SYNC_STAGES] & ss_h & ~ss_s;
  assign sck_rise = sck_s & ~sck_h;
  assign sck_fall = ~sck_s & sck_h;

  assign bus.spi_io_dout = tx_sr[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ss_sync  <= '1;
      sck_sync <= '0;
      din_sync <= '0;
      ss_h     <= 1'b1;
      sck_h    <= 1'b0;
      fill     <= '0;
    end else begin
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0],  bus.spi_io_ss};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.spi_io_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], bus.spi_io_din};
      ss_h     <= ss_s;
      sck_h    <= sck_s;
      fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_xfer = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (ss_fall) begin
        state_nx   = ACTIVE;
        start_xfer = 1'b1;
      end
      ACTIVE: if (ss_s) begin
        // ss rise beats a completing SCK rise in the same cycle
        state_nx = IDLE;
        abort    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.data_in        <= 8'h00;
      bus.data_in_strobe <= 1'b0;
      bus.data_in_start  <= 1'b0;
      rx_sr              <= 8'h00;
      tx_sr              <= 8'h00;
      bit_cnt            <= 3'd0;
      first              <= 1'b1;
      byte_done          <= 1'b0;
      reload_pend        <= 1'b0;
    end else begin
      bus.data_in_strobe <= 1'b0;
      bus.data_in_start  <= 1'b0;
      if (start_xfer) begin
        bit_cnt     <= 3'd0;
        first       <= 1'b1;
        tx_sr       <= bus.data_out;
        rx_sr       <= 8'h00;
        byte_done   <= 1'b0;
        reload_pend <= 1'b0;
      end else if (abort) begin
        bit_cnt     <= 3'd0;
        first       <= 1'b1;
        byte_done   <= 1'b0;
        reload_pend <= 1'b0;
      end else if (state == ACTIVE) begin
        byte_done   <= sck_rise && (bit_cnt == 3'd7);
        reload_pend <= bus.data_in_strobe;
        if (sck_rise) begin
          rx_sr   <= {rx_sr[6:0], din_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          bus.data_in        <= rx_sr;
          bus.data_in_strobe <= 1'b1;
          bus.data_in_start  <= first;
          first              <= 1'b0;
        end
        // Falling edge closing a byte (bit_cnt wrapped to 0) must not shift,
        // the freshly loaded reply MSB has to stay on MISO.
        if (reload_pend)
          tx_sr <= bus.data_out;
        else if (sck_fall && (bit_cnt != 3'd0))
          tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule
